// File: rtl/onehot_bitmap_encoder_pkg.sv
// Shared types and sizing helpers for the serializing one-hot bitmap encoder.
// Optional feature macro: ONEHOT_ENC_ZERO_BEAT_EN (all-zero vectors emit a marker beat).
package onehot_enc_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  // Index width for a request vector of width w.
  function automatic int unsigned idx_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/onehot_bitmap_encoder_if.sv
// Request-in / index-out handshake bundle for onehot_bitmap_encoder.
interface onehot_bitmap_encoder_if
  import onehot_enc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  localparam int unsigned IDX_W = idx_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;

  // Producer/consumer side driving the encoder.
  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_zero
  );

  // Encoder side.
  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_zero
  );

endinterface

// File: rtl/onehot_bitmap_encoder_lsb_finder.sv
// Combinational lowest-set-bit finder: binary index, one-hot mask and single-bit flag.
module lsb_finder
  import onehot_enc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             single_o
);

  logic [WIDTH-1:0] below_lsb;

  // Two's-complement trick isolates the lowest set bit; zero input gives zero mask.
  assign mask_o    = vec_i & (~vec_i + WIDTH'(1));
  assign below_lsb = vec_i - WIDTH'(1);
  assign single_o  = (vec_i != '0) && ((vec_i & below_lsb) == '0);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_bitmap_encoder.sv
// Serializes a request bitmap into one binary index per output beat, lowest first.
// Optional feature macro: ONEHOT_ENC_ZERO_BEAT_EN (all-zero vector emits one out_zero beat).
module onehot_bitmap_encoder
  import onehot_enc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  onehot_bitmap_encoder_if.slave  bus
);

  localparam int unsigned IDX_W = idx_w(WIDTH);

  enc_state_e       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] lsb_idx;
  logic [WIDTH-1:0] lsb_mask;
  logic             lsb_single;
  logic             emit;
  logic             out_hs;

  lsb_finder #(.WIDTH(WIDTH)) u_lsb_finder (
    .vec_i    (pending_q),
    .idx_o    (lsb_idx),
    .mask_o   (lsb_mask),
    .single_o (lsb_single)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

  assign emit   = (state_q == EMIT);
  assign out_hs = emit && bus.out_ready;

  // Next-state and handshake outputs; outputs depend on registered state (and rst) only.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    zero_d        = zero_q;
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = emit;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          if (bus.in_vec != '0) begin
            state_d = EMIT;
          end else begin
`ifdef ONEHOT_ENC_ZERO_BEAT_EN
            state_d = EMIT;
            zero_d  = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      EMIT: begin
        if (out_hs) begin
          pending_d = pending_q & ~lsb_mask;
          if (lsb_single || zero_q) begin
            state_d = IDLE;
            zero_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_idx  = lsb_idx;
  assign bus.out_last = emit && (lsb_single || zero_q);
`ifdef ONEHOT_ENC_ZERO_BEAT_EN
  assign bus.out_zero = emit && zero_q;
`else
  assign bus.out_zero = 1'b0;
`endif

  // A stalled beat must hold until it is taken.
  a_hold_stall: assert property (@(posedge clk) disable iff (rst)
    (emit && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_idx) && $stable(bus.out_last)));

  // Never accept and emit in the same cycle.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_onehot_bitmap_encoder.sv
// Self-checking bench for onehot_bitmap_encoder: vector table, corner sequences, random round trip.
module tb_onehot_bitmap_encoder;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;

  onehot_bitmap_encoder_if #(.WIDTH(WIDTH)) bus ();

  onehot_bitmap_encoder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [7:0] vec;
    int         first;
    int         beats;
    int         last_idx;
  } vec_rec_t;

  vec_rec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 3-to-8 one-hot decoder with enable, as the downstream block would see it.
  function automatic logic [7:0] decode3(input logic [2:0] idx, input logic en);
    logic [7:0] one;
    one = 8'd1;
    return en ? (one << idx) : 8'd0;
  endfunction

  // Present a vector and complete the input handshake.
  task automatic send(input logic [7:0] vec);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = vec;
    step();
    bus.in_valid = 1'b0;
    bus.in_vec   = $urandom();
  endtask

  // Drive one nonzero vector and check every beat against the ordered set-bit list.
  task automatic run_vec(input logic [7:0] vec, input bit rnd_ready,
                         output int beats, output int first, output int last_idx);
    int         q[$];
    logic [7:0] dec;
    int         guard;
    int         prev_idx;
    bit         done;
    for (int i = 0; i < 8; i++) if (vec[i]) q.push_back(i);
    beats = 0; first = -1; last_idx = -1; dec = '0; done = 0;
    bus.out_ready = 1'b0;
    send(vec);
    check("latency_out_valid", int'(bus.out_valid), 1);
    guard = 0;
    while (!done && guard < 200) begin
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!bus.out_valid) begin
        check("beat_out_valid", 0, 1);
        break;
      end
      check("beat_idx", int'(bus.out_idx), (q.size() > 0) ? q[0] : -1);
      check("beat_last", int'(bus.out_last), int'(q.size() == 1));
      check("beat_zero", int'(bus.out_zero), 0);
      prev_idx = int'(bus.out_idx);
      if (bus.out_ready) begin
        if (beats == 0) first = prev_idx;
        last_idx = prev_idx;
        beats++;
        dec |= decode3(bus.out_idx, 1'b1);
        if (q.size() > 0) void'(q.pop_front());
        done = bus.out_last;
      end
      step();
      if (!done && !bus.out_ready) check("stall_idx_stable", int'(bus.out_idx), prev_idx);
      guard++;
    end
    bus.out_ready = 1'b0;
    if (!done) check("beat_budget_expired", 0, 1);
    check("roundtrip_or", int'(dec), int'(vec));
    check("beat_count", beats, $countones(vec));
    check("in_ready_after_last", int'(bus.in_ready), 1);
    check("out_valid_after_last", int'(bus.out_valid), 0);
  endtask

  initial begin
    int beats, first, last_idx;
    logic [7:0] v;
    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{8'b1010_0100, 2, 3, 7};
    tbl[1] = '{8'h01, 0, 1, 0};
    tbl[2] = '{8'h80, 7, 1, 7};
    tbl[3] = '{8'hFF, 0, 8, 7};
    tbl[4] = '{8'h18, 3, 2, 4};
    tbl[5] = '{8'h55, 0, 4, 6};

    // Reset held two cycles with in_valid asserted.
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_vec    = 8'hFF;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_idx", int'(bus.out_idx), 0);
      check("rst_out_last", int'(bus.out_last), 0);
      check("rst_out_zero", int'(bus.out_zero), 0);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rel_in_ready", int'(bus.in_ready), 1);

    // Table of vectors with hand-derived first/count/last.
    for (int t = 0; t < 6; t++) begin
      run_vec(tbl[t].vec, 1'b0, beats, first, last_idx);
      check("tbl_first", first, tbl[t].first);
      check("tbl_beats", beats, tbl[t].beats);
      check("tbl_last_idx", last_idx, tbl[t].last_idx);
    end

    // Backpressure: 0x81 stalled three cycles.
    send(8'h81);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_out_idx", int'(bus.out_idx), 0);
      check("bp_out_last", int'(bus.out_last), 0);
      step();
    end
    bus.out_ready = 1'b1;
    check("bp_idx0", int'(bus.out_idx), 0);
    step();
    check("bp_idx7", int'(bus.out_idx), 7);
    check("bp_last7", int'(bus.out_last), 1);
    step();
    bus.out_ready = 1'b0;
    check("bp_in_ready", int'(bus.in_ready), 1);
    check("bp_out_valid_end", int'(bus.out_valid), 0);

    // All-zero vector.
    bus.out_ready = 1'b1;
    send(8'h00);
`ifdef ONEHOT_ENC_ZERO_BEAT_EN
    check("zero_out_valid", int'(bus.out_valid), 1);
    check("zero_out_idx", int'(bus.out_idx), 0);
    check("zero_out_last", int'(bus.out_last), 1);
    check("zero_out_zero", int'(bus.out_zero), 1);
    step();
    check("zero_done_valid", int'(bus.out_valid), 0);
    check("zero_done_ready", int'(bus.in_ready), 1);
`else
    check("zero_out_valid", int'(bus.out_valid), 0);
    check("zero_in_ready", int'(bus.in_ready), 1);
    step();
    check("zero_out_valid_2", int'(bus.out_valid), 0);
    check("zero_out_zero", int'(bus.out_zero), 0);
`endif
    bus.out_ready = 1'b0;

    // Reset in the middle of 0xFF after three beats.
    send(8'hFF);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_idx", int'(bus.out_idx), i);
      step();
    end
    rst = 1'b1;
    step();
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_idx", int'(bus.out_idx), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_beat", int'(bus.out_valid), 0);
    end
    run_vec(8'h10, 1'b0, beats, first, last_idx);
    check("mid_next_beats", beats, 1);
    check("mid_next_idx", first, 4);

    // Random nonzero vectors with random backpressure.
    for (int r = 0; r < 60; r++) begin
      v = 8'($urandom_range(1, 255));
      run_vec(v, 1'b1, beats, first, last_idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, miscompares so far %0d", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/onehot_bitmap_encoder.md
# onehot_bitmap_encoder

Serializing bitmap encoder, the inverse of the team's 3-to-8 one-hot decoder. Accepts a WIDTH-bit request vector over a valid/ready handshake and emits the binary index of every set bit, lowest first, one index per output handshake. Sits upstream of the decoder in request/grant paths: feeding each emitted index into the decoder reproduces the bit being retired.

## Interface
- WIDTH, 8, request vector width; power of two, at least 2; IDX_W = $clog2(WIDTH) is derived, not a parameter.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vec is valid this cycle.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  request bitmap.
- out_valid  output  1  out_idx is valid this cycle.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  IDX_W  index of the lowest remaining set bit.
- out_last  output  1  this beat is the final beat for the current vector.
- out_zero  output  1  beat reports an all-zero vector; tied 0 unless ONEHOT_ENC_ZERO_BEAT_EN is defined.

## Operation
- States are IDLE and EMIT. The internal register `pending` is WIDTH bits wide.
- IDLE:
  - in_ready = 1. out_valid = 0.
  - On in_valid && in_ready, load `pending` from in_vec.
  - A nonzero vector moves to EMIT.
  - A zero vector is handled as described under Configuration.
- EMIT:
  - out_valid = 1. in_ready = 0.
  - out_idx = index of the lowest set bit of `pending`.
  - out_last = 1 when exactly one bit of `pending` is set.
- On out_valid && out_ready:
  - Clear the bit at out_idx in `pending`.
  - If out_last = 1, go to IDLE. Otherwise stay in EMIT.
- With out_ready low, `pending`, out_idx and out_last hold stable. out_valid stays 1 and never drops without a handshake.
- in_valid is ignored in EMIT. The upstream must hold its vector until in_ready.
- Output count per vector = popcount(in_vec), ranging from 1 to WIDTH.
- Indices are strictly increasing within a vector and never repeat.

## Timing
- Reset values:
  - state = IDLE, pending = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst is released.
- Latency: a vector accepted at edge N gives out_valid = 1 in cycle N+1.
- Throughput: with out_ready held high, one index per cycle.
  - After the last-beat handshake, in_ready rises the next cycle. There is no overlap between vectors.
  - A vector with k set bits occupies k+1 cycles from acceptance to the next in_ready.
- rst asserted mid-EMIT: at the next edge, remaining beats are discarded and all outputs return to reset values. Nothing is emitted after reset.
- rst wins over a simultaneous in or out handshake.
- out_idx, out_last and out_zero are combinational from registered state only. There is no combinational path from in_* to out_*, and none from out_ready to in_ready.

## Configuration
- ONEHOT_ENC_ZERO_BEAT_EN defined:
  - An accepted all-zero vector goes to EMIT and produces exactly one beat with out_idx = 0, out_last = 1, out_zero = 1.
  - out_zero = 0 on every other beat.
- ONEHOT_ENC_ZERO_BEAT_EN undefined:
  - An accepted all-zero vector is consumed and silently dropped. State stays IDLE and in_ready stays 1.
  - out_zero is constant 0.

## Structure
- Package onehot_enc_pkg contains:
  - the state enum (IDLE, EMIT);
  - the default WIDTH localparam;
  - a function computing IDX_W.
- One sub-module, lsb_finder: combinational, WIDTH in, giving the lowest-set-bit index, the one-hot mask of that bit, and a single-bit flag.
  - The top-level block uses the mask to clear `pending` and the flag to drive out_last.

## Test plan
- Reset: hold rst high 2 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, out_idx = 0 throughout; in_ready = 1 in the first cycle after release.
- in_vec = 8'b1010_0100, out_ready = 1 → out_idx 2, 5, 7 on three consecutive cycles; out_last only on 7; in_ready = 1 the following cycle.
- Backpressure: in_vec = 8'b1000_0001, out_ready low 3 cycles → out_valid = 1 and out_idx = 0 stable for 3 cycles; then idx 0 followed by idx 7 with out_last = 1.
- Zero vector: in_vec = 8'h00 → without the macro, no beat and in_ready stays 1; with the macro, one beat with out_idx = 0, out_zero = 1, out_last = 1.
- Reset mid-operation: in_vec = 8'hFF; after beats 0, 1, 2, assert rst for 1 cycle → out_valid = 0 at the next edge, no further beats, next vector 8'h10 yields a single beat idx 4 with out_last = 1.
- Round trip: apply random nonzero vectors and pass each out_idx through the 3-to-8 decoder with enable = 1 → the OR of the decoded outputs equals in_vec, and the beat count equals popcount.
